// File: rtl/sat_unary_lanes.sv
// sat_unary_lanes
// Multi-lane two's-complement unary unit with per-lane saturation.
// Each accepted beat carries LANES signed elements and one operation
// (PASS, NEG, ABS, DBL) that applies to every lane of that beat. The
// datapath is a two-stage valid/ready pipeline: S1 holds the operands and
// the unsaturated WIDTH+1-bit results, and S2 holds the saturated output.
// Sticky overflow status and an overflow beat counter advance only when a
// beat is actually handed downstream.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_data [LANES*WIDTH]   lane i at [i*WIDTH +: WIDTH]
//   in_mode [2]             0 PASS, 1 NEG, 2 ABS, 3 DBL
//   out_valid/out_ready     output handshake
//   out_data [LANES*WIDTH]  saturated results, same lane packing
//   out_ovf  [LANES]        per-lane saturation flags for out_data
//   clr_ovf                 synchronous clear of the status below
//   sticky_ovf              set by any delivered beat with an overflow lane
//   ovf_count [CNT_W]       count of such beats, saturating at all-ones
module sat_unary_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_ovf,
    input  logic                     clr_ovf,
    output logic                     sticky_ovf,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int RW = WIDTH + 1;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_NEG  = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;
    localparam logic [1:0] MODE_DBL  = 2'd3;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // One extra bit of headroom is enough for every mode: -MIN and 2*x
    // both fit in WIDTH+1 signed bits, so saturation can be decided later.
    function automatic logic [RW-1:0] raw_result(input logic [WIDTH-1:0] x,
                                                 input logic [1:0]       mode);
        logic [RW-1:0] xe;
        xe = {x[WIDTH-1], x};
        case (mode)
            MODE_NEG: raw_result = -xe;
            MODE_ABS: raw_result = x[WIDTH-1] ? -xe : xe;
            MODE_DBL: raw_result = {x, 1'b0};
            default:  raw_result = xe;
        endcase
    endfunction

    logic                     s1_valid_q;
    logic [LANES*WIDTH-1:0]   s1_opnd_q;
    logic [1:0]               s1_mode_q;
    logic [LANES*RW-1:0]      s1_raw_q;
    logic [LANES*RW-1:0]      s1_raw_d;

    logic                     out_valid_q;
    logic [LANES*WIDTH-1:0]   out_data_q;
    logic [LANES*WIDTH-1:0]   out_data_d;
    logic [LANES-1:0]         out_ovf_q;
    logic [LANES-1:0]         out_ovf_d;

    logic                     sticky_q;
    logic [CNT_W-1:0]         count_q;

    logic                     s1_ready;
    logic                     s2_ready;
    logic                     deliver;
    logic                     ovf_event;

    // A stage may load when it is empty or its content leaves this cycle,
    // which lets S2 drain and S1 advance on the same edge.
    assign s2_ready  = !out_valid_q || out_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign in_ready  = s1_ready;

    assign deliver   = out_valid_q && out_ready;
    assign ovf_event = deliver && (|out_ovf_q);

    always_comb begin
        s1_raw_d = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_raw_d[i*RW +: RW] = raw_result(in_data[i*WIDTH +: WIDTH], in_mode);
        end
    end

    // A lane overflowed when the two top bits of its wide result disagree;
    // the top bit then tells which rail to clamp to. PASS can never
    // overflow, so it forwards the registered operand untouched.
    always_comb begin
        out_data_d = '0;
        out_ovf_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mode_q == MODE_PASS) begin
                out_data_d[i*WIDTH +: WIDTH] = s1_opnd_q[i*WIDTH +: WIDTH];
            end else if (s1_raw_q[i*RW + WIDTH] != s1_raw_q[i*RW + WIDTH - 1]) begin
                out_ovf_d[i]                 = 1'b1;
                out_data_d[i*WIDTH +: WIDTH] = s1_raw_q[i*RW + WIDTH] ? SAT_MIN : SAT_MAX;
            end else begin
                out_data_d[i*WIDTH +: WIDTH] = s1_raw_q[i*RW +: WIDTH];
            end
        end
    end

    // S1: capture operands, mode and wide results on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_opnd_q  <= '0;
            s1_mode_q  <= MODE_PASS;
            s1_raw_q   <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_opnd_q <= in_data;
                s1_mode_q <= in_mode;
                s1_raw_q  <= s1_raw_d;
            end
        end
    end

    // S2: saturated output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_ovf_q  <= out_ovf_d;
            end
        end
    end

    // Status: an overflow delivery in the same cycle as a clear is kept
    // as the first event after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (clr_ovf) begin
            sticky_q <= ovf_event;
            count_q  <= ovf_event ? CNT_W'(1) : '0;
        end else if (ovf_event) begin
            sticky_q <= 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign sticky_ovf = sticky_q;
    assign ovf_count  = count_q;

endmodule

// File: tb/tb_sat_unary_lanes.sv
// tb_sat_unary_lanes
// Self-checking bench for sat_unary_lanes (WIDTH=8, LANES=4). Expected
// beats are computed by an integer reference model and queued when a beat
// is accepted; a monitor pops and compares on every delivery. A second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_sat_unary_lanes;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam int MINV  = -(1 << (WIDTH - 1));

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [1:0]             in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_ovf;
    logic                   clr_ovf;
    logic                   sticky_ovf;
    logic [CNT_W-1:0]       ovf_count;

    logic                   in_ready2;
    logic                   out_valid2;
    logic [LANES*WIDTH-1:0] out_data2;
    logic [LANES-1:0]       out_ovf2;
    logic                   sticky_ovf2;
    logic [1:0]             ovf_count2;

    int testsRun  = 0;
    int failCount = 0;

    logic [LANES*WIDTH-1:0] expData[$];
    logic [LANES-1:0]       expOvf[$];

    sat_unary_lanes #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf),
        .clr_ovf(clr_ovf), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
    );

    sat_unary_lanes #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(2)) dutSmall (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_ovf(out_ovf2),
        .clr_ovf(clr_ovf), .sticky_ovf(sticky_ovf2), .ovf_count(ovf_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact integer arithmetic, then clamp to the range.
    function automatic logic [LANES*WIDTH+LANES-1:0] modelBeat(input logic [LANES*WIDTH-1:0] d,
                                                               input logic [1:0] m);
        logic [LANES*WIDTH-1:0] r;
        logic [LANES-1:0]       o;
        logic [WIDTH-1:0]       lane;
        int v;
        int y;
        r = '0;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = d[i*WIDTH +: WIDTH];
            v = int'($signed(lane));
            case (m)
                2'd0:    y = v;
                2'd1:    y = -v;
                2'd2:    y = (v < 0) ? -v : v;
                default: y = 2 * v;
            endcase
            o[i] = (y > MAXV) || (y < MINV);
            if (y > MAXV) y = MAXV;
            if (y < MINV) y = MINV;
            r[i*WIDTH +: WIDTH] = WIDTH'(y);
        end
        return {o, r};
    endfunction

    task automatic pushExpected(input logic [LANES*WIDTH-1:0] d, input logic [1:0] m);
        logic [LANES*WIDTH+LANES-1:0] e;
        e = modelBeat(d, m);
        expData.push_back(e[LANES*WIDTH-1:0]);
        expOvf.push_back(e[LANES*WIDTH +: LANES]);
    endtask

    // Scoreboard monitor: every delivery is checked against the model.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            testsRun++;
            if (expData.size() == 0) begin
                failCount++;
                $display("[TB] FAIL scoreboard_unexpected: got data %h ovf %b, expected no beat", out_data, out_ovf);
            end else begin
                logic [LANES*WIDTH-1:0] ed;
                logic [LANES-1:0]       eo;
                ed = expData.pop_front();
                eo = expOvf.pop_front();
                if (out_data !== ed || out_ovf !== eo) begin
                    failCount++;
                    $display("[TB] FAIL scoreboard_beat: got data %h ovf %b, expected data %h ovf %b", out_data, out_ovf, ed, eo);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic driveBeat(input logic [LANES*WIDTH-1:0] d, input logic [1:0] m);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready) begin
                pushExpected(d, m);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        testsRun++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== '0 ||
            sticky_ovf !== 1'b0 || ovf_count !== '0 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_state: got v%b d%h o%b s%b c%0d r%b, expected v0 d0 o0 s0 c0 r1",
                     out_valid, out_data, out_ovf, sticky_ovf, ovf_count, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_neg;
        out_ready = 1'b1;
        driveBeat({8'h01, 8'h00, 8'h7F, 8'h80}, 2'd1);
        testsRun++;
        if (out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL neg_latency_early: got out_valid %b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== {8'hFF, 8'h00, 8'h81, 8'h7F} || out_ovf !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL neg_result: got v%b %h ovf %b, expected v1 ff00817f ovf 0001", out_valid, out_data, out_ovf);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (sticky_ovf !== 1'b1 || ovf_count !== 16'd1) begin
            failCount++;
            $display("[TB] FAIL neg_status: got sticky %b count %0d, expected 1 1", sticky_ovf, ovf_count);
        end
    endtask

    task automatic test_abs_pass;
        out_ready = 1'b1;
        driveBeat({8'h81, 8'h05, 8'hFF, 8'h80}, 2'd2);
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== {8'h7F, 8'h05, 8'h01, 8'h7F} || out_ovf !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL abs_result: got v%b %h ovf %b, expected v1 7f05017f ovf 0001", out_valid, out_data, out_ovf);
        end
        driveBeat({8'h81, 8'h05, 8'hFF, 8'h80}, 2'd0);
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== {8'h81, 8'h05, 8'hFF, 8'h80} || out_ovf !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL pass_result: got v%b %h ovf %b, expected v1 8105ff80 ovf 0000", out_valid, out_data, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dbl;
        out_ready = 1'b1;
        driveBeat({8'h3F, 8'hBF, 8'hC0, 8'h40}, 2'd3);
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== {8'h7E, 8'h80, 8'h80, 8'h7F} || out_ovf !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL dbl_result: got v%b %h ovf %b, expected v1 7e80807f ovf 0101", out_valid, out_data, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [LANES*WIDTH-1:0] bpData[5];
        logic [1:0]             bpMode[5];
        int  sent;
        int  acceptsStalled;
        int  readyWhileFull;
        int  delivered;
        int  firstDel;
        int  lastDel;
        bit  took;
        for (int i = 0; i < 5; i++) begin
            bpData[i] = $urandom;
            bpMode[i] = 2'($urandom_range(0, 3));
        end
        sent = 0;
        acceptsStalled = 0;
        readyWhileFull = 0;
        delivered = 0;
        firstDel = -1;
        lastDel = -1;
        for (int k = 0; k < 40 && delivered < 5; k++) begin
            out_ready = (k >= 6);
            if (sent < 5) begin
                in_valid = 1'b1;
                in_data  = bpData[sent];
                in_mode  = bpMode[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) begin
                pushExpected(in_data, in_mode);
                if (k < 6) acceptsStalled++;
            end
            if (k >= 2 && k < 6 && in_ready) readyWhileFull++;
            if (out_valid && out_ready) begin
                if (firstDel < 0) firstDel = k;
                lastDel = k;
                delivered++;
            end
            @(posedge clk);
            #1;
            if (took) sent++;
        end
        in_valid = 1'b0;
        testsRun++;
        if (acceptsStalled !== 2 || readyWhileFull !== 0) begin
            failCount++;
            $display("[TB] FAIL bp_fill: got %0d accepts, %0d ready cycles while full, expected 2 and 0", acceptsStalled, readyWhileFull);
        end
        testsRun++;
        if (delivered !== 5 || lastDel - firstDel !== 4) begin
            failCount++;
            $display("[TB] FAIL bp_drain: got %0d beats over span %0d, expected 5 over span 4", delivered, lastDel - firstDel);
        end
    endtask

    task automatic test_status;
        bit seen;
        out_ready = 1'b1;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        for (int i = 0; i < 3; i++) driveBeat({8'h00, 8'h00, 8'h00, 8'h80}, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (ovf_count !== 16'd3 || sticky_ovf !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL status_three: got count %0d sticky %b, expected 3 1", ovf_count, sticky_ovf);
        end
        out_ready = 1'b0;
        driveBeat({8'h00, 8'h00, 8'h00, 8'h80}, 2'd2);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        testsRun++;
        if (!seen) begin
            failCount++;
            $display("[TB] FAIL status_wait: got out_valid 0, expected 1 within 10 cycles");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        testsRun++;
        if (ovf_count !== 16'd1 || sticky_ovf !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL status_clr_with_event: got count %0d sticky %b, expected 1 1", ovf_count, sticky_ovf);
        end
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        testsRun++;
        if (ovf_count !== 16'd0 || sticky_ovf !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL status_clr_alone: got count %0d sticky %b, expected 0 0", ovf_count, sticky_ovf);
        end
    endtask

    task automatic test_count_saturation;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) driveBeat({8'h7F, 8'h00, 8'h00, 8'h40}, 2'd3);
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (ovf_count2 !== 2'd3 || sticky_ovf2 !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL count_saturate: got count %0d sticky %b, expected 3 1", ovf_count2, sticky_ovf2);
        end
        testsRun++;
        if (ovf_count !== 16'd5) begin
            failCount++;
            $display("[TB] FAIL count_wide: got count %0d, expected 5", ovf_count);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        driveBeat({8'h11, 8'h22, 8'h33, 8'h80}, 2'd1);
        driveBeat({8'h44, 8'h55, 8'h66, 8'h80}, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== '0 ||
            sticky_ovf !== 1'b0 || ovf_count !== '0 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_midstream: got v%b d%h o%b s%b c%0d r%b, expected v0 d0 o0 s0 c0 r1",
                     out_valid, out_data, out_ovf, sticky_ovf, ovf_count, in_ready);
        end
        expData.delete();
        expOvf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        driveBeat({8'h0A, 8'h0B, 8'h0C, 8'h0D}, 2'd0);
        testsRun++;
        if (out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL post_reset_early: got out_valid %b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== {8'h0A, 8'h0B, 8'h0C, 8'h0D} || out_ovf !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL post_reset_beat: got v%b %h ovf %b, expected v1 0a0b0c0d ovf 0000", out_valid, out_data, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        test_reset();
        test_neg();
        test_abs_pass();
        test_dbl();
        test_back_to_back();
        test_status();
        test_count_saturation();
        test_reset_midstream();
        repeat (4) @(posedge clk);
        #1;
        testsRun++;
        if (expData.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_leftover: got %0d undelivered beats, expected 0", expData.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
